// File: rtl/riscv_dmem_ctrl.sv
// RV32I data-memory controller: one outstanding request, fixed-latency response,
// byte-lane stores, sign/zero-extended loads and error reporting.
module riscv_dmem_ctrl #(
    parameter int DEPTH   = 1024,
    parameter int LATENCY = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     req_valid,
    output logic                     req_ready,
    input  logic                     req_we,
    input  logic [31:0]              req_addr,
    input  logic [31:0]              req_wdata,
    input  logic [2:0]               req_funct3,
    output logic                     rsp_valid,
    input  logic                     rsp_ready,
    output logic [31:0]              rsp_rdata,
    output logic                     rsp_err,
    input  logic [$clog2(DEPTH)-1:0] dbg_addr,
    output logic [31:0]              dbg_rdata
);
    localparam int         AW     = $clog2(DEPTH);
    localparam logic [3:0] LAST   = 4'(LATENCY - 1);
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_WAIT = 2'd1;
    localparam logic [1:0] S_RESP = 2'd2;

    logic [1:0]  state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        rsp_valid_q, rsp_valid_d;
    logic        rsp_err_q, rsp_err_d;
    logic [31:0] rsp_rdata_q, rsp_rdata_d;
    logic        we_q, we_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [2:0]  f3_q, f3_d;

    logic [31:0] mem [DEPTH];

    logic [AW-1:0] widx;
    logic          legal, misal, hi_err, err, commit;
    logic [3:0]    be;
    logic [31:0]   wd;

    function automatic logic [31:0] load_ext(input logic [31:0] word,
                                             input logic [1:0]  off,
                                             input logic [2:0]  f3);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] r;
        b = word[8*off +: 8];
        h = off[1] ? word[31:16] : word[15:0];
        case (f3)
            3'b000:  r = {{24{b[7]}}, b};
            3'b001:  r = {{16{h[15]}}, h};
            3'b100:  r = {24'b0, b};
            3'b101:  r = {16'b0, h};
            default: r = word;
        endcase
        return r;
    endfunction

    // Legality is judged on the registered request so late input changes cannot matter.
    assign widx   = addr_q[AW+1:2];
    assign hi_err = |(addr_q >> (AW + 2));
    assign legal  = we_q ? (f3_q inside {3'b000, 3'b001, 3'b010})
                         : (f3_q inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101});
    assign misal  = ((f3_q[1:0] == 2'b01) && addr_q[0]) ||
                    ((f3_q[1:0] == 2'b10) && (addr_q[1:0] != 2'b00));
    assign err    = !legal || misal || hi_err;
    assign commit = (state_q == S_WAIT) && (cnt_q == LAST);

    always_comb begin
        be = 4'hF;
        wd = wdata_q;
        case (f3_q[1:0])
            2'b00: begin
                be = 4'b0001 << addr_q[1:0];
                wd = {4{wdata_q[7:0]}};
            end
            2'b01: begin
                be = addr_q[1] ? 4'b1100 : 4'b0011;
                wd = {2{wdata_q[15:0]}};
            end
            default: ;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        rsp_valid_d = rsp_valid_q;
        rsp_err_d   = rsp_err_q;
        rsp_rdata_d = rsp_rdata_q;
        we_d        = we_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        f3_d        = f3_q;
        case (state_q)
            S_IDLE: if (req_valid) begin
                state_d = S_WAIT;
                cnt_d   = 4'd0;
                we_d    = req_we;
                addr_d  = req_addr;
                wdata_d = req_wdata;
                f3_d    = req_funct3;
            end
            S_WAIT: if (commit) begin
                state_d     = S_RESP;
                rsp_valid_d = 1'b1;
                rsp_err_d   = err;
                rsp_rdata_d = (err || we_q) ? 32'h0 : load_ext(mem[widx], addr_q[1:0], f3_q);
            end else begin
                cnt_d = cnt_q + 4'd1;
            end
            S_RESP: if (rsp_ready) begin
                state_d     = S_IDLE;
                rsp_valid_d = 1'b0;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            cnt_q       <= 4'd0;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_rdata_q <= 32'h0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_err_q   <= rsp_err_d;
            rsp_rdata_q <= rsp_rdata_d;
        end
    end

    always_ff @(posedge clk) begin
        we_q    <= we_d;
        addr_q  <= addr_d;
        wdata_q <= wdata_d;
        f3_q    <= f3_d;
    end

    // Reset outranks a commit landing on the same edge.
    always_ff @(posedge clk) begin
        if (!rst && commit && we_q && !err) begin
            for (int i = 0; i < 4; i++) begin
                if (be[i]) mem[widx][8*i +: 8] <= wd[8*i +: 8];
            end
        end
    end

    assign req_ready = (state_q == S_IDLE);
    assign rsp_valid = rsp_valid_q;
    assign rsp_err   = rsp_err_q;
    assign rsp_rdata = rsp_rdata_q;
    assign dbg_rdata = mem[dbg_addr];
endmodule

// File: tb/tb_riscv_dmem_ctrl.sv
// Bench for riscv_dmem_ctrl: behavioural memory model with a per-cycle compare,
// directed literal scenarios, then randomized traffic with occasional resets.
module tb_riscv_dmem_ctrl;
    localparam int DEPTH   = 1024;
    localparam int LATENCY = 2;
    localparam int AW      = 10;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          req_valid = 1'b0;
    logic          req_ready;
    logic          req_we = 1'b0;
    logic [31:0]   req_addr = '0;
    logic [31:0]   req_wdata = '0;
    logic [2:0]    req_funct3 = '0;
    logic          rsp_valid;
    logic          rsp_ready = 1'b0;
    logic [31:0]   rsp_rdata;
    logic          rsp_err;
    logic [AW-1:0] dbg_addr = '0;
    logic [31:0]   dbg_rdata;

    riscv_dmem_ctrl #(.DEPTH(DEPTH), .LATENCY(LATENCY)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_funct3(req_funct3),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
        .rsp_err(rsp_err), .dbg_addr(dbg_addr), .dbg_rdata(dbg_rdata)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    int last_wait = 0;
    logic [31:0] pre [64];

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %08h expected %08h", name, got, exp);
        end
    endtask

    // Behavioural model: memory as a word array, transaction as "accepted, then
    // LATENCY edges later the result appears and any store lands".
    logic [31:0] m_mem [DEPTH];
    bit          m_known [DEPTH];
    bit          m_busy, m_resp, m_started, m_just_rst;
    int          m_age;
    logic        a_we;
    logic [31:0] a_addr, a_wdata;
    logic [2:0]  a_f3;
    logic [31:0] m_rdata;
    logic        m_err;

    task automatic model_exec();
        bit          legal;
        int          sz, idx;
        logic [31:0] w, sh;
        legal = a_we ? (a_f3 <= 3'd2) : (a_f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
        sz = 1 << a_f3[1:0];
        if (!legal || (a_addr % sz != 0) || (a_addr >= 4 * DEPTH)) begin
            m_rdata = 32'h0;
            m_err   = 1'b1;
        end else begin
            m_err = 1'b0;
            w  = m_mem[a_addr / 4];
            sh = w >> (8 * (a_addr % 4));
            if (a_we) begin
                for (int b = 0; b < sz; b++) begin
                    idx = (a_addr % 4) + b;
                    w[8*idx +: 8] = a_wdata[8*b +: 8];
                end
                m_mem[a_addr / 4]   = w;
                m_known[a_addr / 4] = 1'b1;
                m_rdata = 32'h0;
            end else begin
                case (a_f3)
                    3'd0:    m_rdata = 32'($signed(sh[7:0]));
                    3'd1:    m_rdata = 32'($signed(sh[15:0]));
                    3'd4:    m_rdata = sh & 32'hFF;
                    3'd5:    m_rdata = sh & 32'hFFFF;
                    default: m_rdata = w;
                endcase
            end
        end
    endtask

    always @(posedge clk) begin
        if (rst) begin
            m_busy = 0; m_resp = 0; m_age = 0;
            m_started = 1; m_just_rst = 1;
        end else begin
            m_just_rst = 0;
            if (!m_busy) begin
                if (req_valid) begin
                    m_busy = 1; m_age = 0;
                    a_we = req_we; a_addr = req_addr; a_wdata = req_wdata; a_f3 = req_funct3;
                end
            end else if (!m_resp) begin
                m_age++;
                if (m_age == LATENCY) begin
                    m_resp = 1;
                    model_exec();
                end
            end else if (rsp_ready) begin
                m_resp = 0; m_busy = 0;
            end
        end
    end

    always @(posedge clk) begin
        #1;
        if (m_started) begin
            chk("cmp req_ready", 32'(req_ready), 32'(!m_busy));
            chk("cmp rsp_valid", 32'(rsp_valid), 32'(m_resp));
            if (m_resp) begin
                chk("cmp rsp_rdata", rsp_rdata, m_rdata);
                chk("cmp rsp_err", 32'(rsp_err), 32'(m_err));
            end
            if (m_just_rst) begin
                chk("reset rsp_rdata", rsp_rdata, 32'h0);
                chk("reset rsp_err", 32'(rsp_err), 32'h0);
            end
            if (m_known[dbg_addr]) chk("cmp dbg_rdata", dbg_rdata, m_mem[dbg_addr]);
        end
    end

    // Called on a negedge; returns on a negedge with the response consumed.
    task automatic xact(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [2:0] f3, input logic [31:0] exp_rd, input logic exp_err,
                        input int hold, input string name);
        int waited = 0;
        int lat = 0;
        while (!req_ready && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        last_wait = waited;
        if (!req_ready) begin
            chk({name, " accept timeout"}, 32'(req_ready), 32'h1);
            return;
        end
        req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wdata; req_funct3 = f3;
        @(posedge clk);
        @(negedge clk);
        req_valid  = 1'b0;
        req_we     = ~we;
        req_addr   = $urandom;
        req_wdata  = $urandom;
        req_funct3 = 3'($urandom_range(0, 7));
        while (!rsp_valid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        chk({name, " latency"}, 32'(lat), 32'(LATENCY));
        chk({name, " rdata"}, rsp_rdata, exp_rd);
        chk({name, " err"}, 32'(rsp_err), 32'(exp_err));
        for (int h = 0; h < hold; h++) begin
            chk({name, " hold valid"}, 32'(rsp_valid), 32'h1);
            chk({name, " hold rdata"}, rsp_rdata, exp_rd);
            chk({name, " hold req_ready"}, 32'(req_ready), 32'h0);
            @(negedge clk);
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        chk({name, " idle after consume"}, 32'(req_ready), 32'h1);
    endtask

    task automatic chk_word(input int idx, input logic [31:0] exp, input string name);
        dbg_addr = AW'(idx);
        #1;
        chk(name, dbg_rdata, exp);
    endtask

    initial begin
        foreach (m_mem[i]) begin
            m_mem[i]   = '0;
            m_known[i] = 1'b0;
        end
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        chk("reset req_ready", 32'(req_ready), 32'h1);
        chk("reset rsp_valid", 32'(rsp_valid), 32'h0);
        chk("reset rdata", rsp_rdata, 32'h0);

        for (int i = 0; i < 64; i++) begin
            pre[i] = $urandom;
            xact(1'b1, 32'(i * 4), pre[i], 3'b010, 32'h0, 1'b0, 0, "preload");
        end

        xact(1'b1, 32'h10, 32'hDEADBEEF, 3'b010, 32'h0, 1'b0, 0, "sw 0x10");
        xact(1'b0, 32'h10, 32'h0, 3'b010, 32'hDEADBEEF, 1'b0, 0, "lw 0x10");
        chk_word(4, 32'hDEADBEEF, "dbg word 4");

        xact(1'b1, 32'h80, 32'h80FF7F01, 3'b010, 32'h0, 1'b0, 0, "sw 0x80");
        xact(1'b0, 32'h83, 32'h0, 3'b000, 32'hFFFFFF80, 1'b0, 0, "lb 0x83");
        xact(1'b0, 32'h83, 32'h0, 3'b100, 32'h00000080, 1'b0, 0, "lbu 0x83");
        xact(1'b0, 32'h82, 32'h0, 3'b001, 32'hFFFF80FF, 1'b0, 0, "lh 0x82");
        xact(1'b0, 32'h80, 32'h0, 3'b101, 32'h00007F01, 1'b0, 0, "lhu 0x80");

        xact(1'b1, 32'h80, 32'h11223344, 3'b010, 32'h0, 1'b0, 0, "sw 0x80 b");
        xact(1'b1, 32'h81, 32'h000000AA, 3'b000, 32'h0, 1'b0, 0, "sb 0x81");
        chk_word(32, 32'h1122AA44, "after sb");
        xact(1'b1, 32'h82, 32'h0000BEEF, 3'b001, 32'h0, 1'b0, 0, "sh 0x82");
        chk_word(32, 32'hBEEFAA44, "after sh");
        xact(1'b0, 32'h80, 32'h0, 3'b010, 32'hBEEFAA44, 1'b0, 0, "lw 0x80");

        xact(1'b0, 32'h02, 32'h0, 3'b010, 32'h0, 1'b1, 0, "lw misaligned");
        xact(1'b1, 32'h01, 32'hFFFFFFFF, 3'b001, 32'h0, 1'b1, 0, "sh misaligned");
        xact(1'b0, 32'h1000, 32'h0, 3'b010, 32'h0, 1'b1, 0, "lw out of range");
        xact(1'b0, 32'h10, 32'h0, 3'b011, 32'h0, 1'b1, 0, "load f3 011");
        xact(1'b1, 32'h10, 32'h0, 3'b011, 32'h0, 1'b1, 0, "store f3 011");
        chk_word(0, pre[0], "word 0 unchanged");
        chk_word(4, 32'hDEADBEEF, "word 4 unchanged");

        xact(1'b0, 32'h10, 32'h0, 3'b010, 32'hDEADBEEF, 1'b0, 5, "stall");
        xact(1'b0, 32'h80, 32'h0, 3'b010, 32'hBEEFAA44, 1'b0, 0, "back to back");
        chk("back to back wait", 32'(last_wait), 32'h0);

        xact(1'b1, 32'h20, 32'h0, 3'b010, 32'h0, 1'b0, 0, "sw 0x20 zero");
        req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h20; req_wdata = 32'h5; req_funct3 = 3'b010;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("rst in wait req_ready", 32'(req_ready), 32'h1);
        for (int i = 0; i < 5; i++) begin
            chk("rst in wait no rsp", 32'(rsp_valid), 32'h0);
            @(negedge clk);
        end
        chk_word(8, 32'h0, "rst in wait word 8");

        req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h20; req_wdata = 32'h7; req_funct3 = 3'b010;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("rst on commit no rsp", 32'(rsp_valid), 32'h0);
        chk_word(8, 32'h0, "rst on commit word 8");

        for (int c = 0; c < 3000; c++) begin
            rst        = ($urandom_range(0, 149) == 0);
            req_valid  = 1'($urandom_range(0, 1));
            req_we     = 1'($urandom_range(0, 1));
            req_funct3 = 3'($urandom_range(0, 7));
            req_addr   = 32'($urandom_range(0, 255));
            if ($urandom_range(0, 15) == 0) req_addr = req_addr | (32'h1 << $urandom_range(12, 31));
            req_wdata  = $urandom;
            rsp_ready  = 1'($urandom_range(0, 1));
            dbg_addr   = AW'($urandom_range(0, 63));
            @(negedge clk);
        end
        rst = 1'b0;
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        repeat (6) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/riscv_dmem_ctrl.md
RISCV_DMEM_CTRL -- requirements
Module: riscv_dmem_ctrl

Interface
REQ-001 SHALL have parameter DEPTH, default 1024, meaning number of 32-bit data words.
REQ-002 SHALL have parameter LATENCY, default 2, meaning edges from request acceptance to response valid; legal values 1 to 15.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-005 SHALL have port req_valid, input, 1 bit: the CPU presents a memory request.
REQ-006 SHALL have port req_ready, output, 1 bit: the block accepts a request this cycle.
REQ-007 SHALL have port req_we, input, 1 bit: 1 = store, 0 = load.
REQ-008 SHALL have port req_addr, input, 32 bits: byte address.
REQ-009 SHALL have port req_wdata, input, 32 bits: store data, right-aligned.
REQ-010 SHALL have port req_funct3, input, 3 bits: RV32I load/store funct3 encoding.
REQ-011 SHALL have port rsp_valid, output, 1 bit: a response is available.
REQ-012 SHALL have port rsp_ready, input, 1 bit: the CPU consumes the response.
REQ-013 SHALL have port rsp_rdata, output, 32 bits: load result after extension; 0 for stores and for errors.
REQ-014 SHALL have port rsp_err, output, 1 bit: the request was misaligned, out of range or had an illegal funct3.
REQ-015 SHALL have port dbg_addr, input, log2(DEPTH) bits: word index for the bench memory dump.
REQ-016 SHALL have port dbg_rdata, output, 32 bits: combinational read of word dbg_addr.

Function
REQ-017 SHALL implement a state machine with states IDLE, WAIT and RESP.
REQ-018 SHALL drive req_ready=1 only in IDLE; a request is accepted on an edge where req_valid and req_ready are both 1.
REQ-019 SHALL register we, addr, wdata and funct3 at acceptance; later input changes SHALL have no effect on the accepted request.
REQ-020 SHALL go IDLE->WAIT on acceptance with counter=0, increment the counter each WAIT edge, and go WAIT->RESP on the edge where counter==LATENCY-1; rsp_valid therefore rises LATENCY edges after acceptance.
REQ-021 SHALL hold rsp_valid=1, rsp_rdata and rsp_err stable in RESP until an edge with rsp_ready=1, then return to IDLE; the earliest next acceptance is the following edge.
REQ-022 SHALL use word index addr[log2(DEPTH)+1:2]; any set address bit above that range SHALL be an error.
REQ-023 SHALL accept legal load funct3 values 000 LB, 001 LH, 010 LW, 100 LBU and 101 LHU; legal store values are 000 SB, 001 SH and 010 SW; every other value SHALL be an error.
REQ-024 SHALL flag misalignment as an error: halfword with addr[0]=1, or word with addr[1:0]!=00.
REQ-025 SHALL sign-extend LB/LH from the selected byte or half (selected by addr[1:0] / addr[1]), zero-extend LBU/LHU, and return LW unmodified.
REQ-026 SHALL, for stores, write only the addressed byte lanes (SB: 1 lane from wdata[7:0]; SH: 2 lanes from wdata[15:0]; SW: 4 lanes) on the WAIT->RESP edge.
REQ-027 SHALL sample load data on the WAIT->RESP edge.
REQ-028 SHALL perform no memory write on any error, and SHALL return rsp_rdata=0 and rsp_err=1 with unchanged latency.
REQ-029 SHALL leave memory contents uninitialised by rst; the bench preloads them.
REQ-030 SHALL give dbg_rdata the post-write value from the edge after a store commits.

Reset
REQ-031 SHALL, on an edge with rst=1, set state=IDLE, counter=0, rsp_valid=0, rsp_err=0 and rsp_rdata=0; req_ready SHALL be 1 after the edge.
REQ-032 SHALL discard any in-flight request on rst; a store not yet at the WAIT->RESP edge SHALL NOT be written, and rst SHALL take priority over a commit on the same edge.

Verification
REQ-033 SHALL pass: SW addr 0x10 wdata 0xDEADBEEF, then LW 0x10 -> rsp_valid 2 edges after each acceptance, rdata 0xDEADBEEF, err 0, dbg_addr=4 reads 0xDEADBEEF.
REQ-034 SHALL pass: word 0x80 = 0x80FF7F01; LB 0x83 -> 0xFFFFFF80; LBU 0x83 -> 0x00000080; LH 0x82 -> 0xFFFF80FF; LHU 0x80 -> 0x00007F01.
REQ-035 SHALL pass: SB 0x81 wdata 0x000000AA onto 0x11223344 -> word becomes 0x1122AA44; SH 0x82 wdata 0xBEEF -> 0xBEEFAA44.
REQ-036 SHALL pass: LW 0x02, SH 0x01, LW 0x1000 and funct3=011 -> each rsp_err=1, rdata 0, memory unchanged.
REQ-037 SHALL pass: rsp_ready held 0 for 5 cycles -> rsp_valid and rdata stable and req_ready=0 throughout; rsp_ready=1 -> IDLE next edge, and a back-to-back request is accepted on the following edge.
REQ-038 SHALL pass: SW 0x20 wdata 0x5 to word holding 0x0, rst pulsed one edge after acceptance -> word stays 0x0, rsp_valid never rises, req_ready=1 after reset.
